// File: rtl/icache_pkg.sv
// icache_pkg: shared state type and width/index helpers for the n-way icache controller.
//   state_t : controller FSM states (INIT sweep, CHECK lookup, FETCH burst, FILL write-back)
//   idx_w   : index width of an n-entry dimension, never below 1
//   oh2idx  : position of the set bit of a one-hot vector (up to 32 bits)
package icache_pkg;
   typedef enum logic [1:0] {INIT, CHECK, FETCH, FILL} state_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int oh2idx(input logic [31:0] oh);
      int idx = 0;
      for (int i = 0; i < 32; i++) if (oh[i]) idx = i;
      return idx;
   endfunction
endpackage

// File: rtl/icache_ctrl_nway_if.sv
// icache_ctrl_nway_if: CPU request, tag-array status, memory port and array-control bundle.
//   master : the controller (drives clr/clr_idx, mem_valid_l1, re_mm, reset_mm, we_cl,
//            cl_word, we_imem, fill_way, fill_set, miss_err)
//   slave  : the surrounding CPU / tag arrays / main memory (drive re_imem, set_idx,
//            hit_way, valid_way, mem_valid_mm, mem_err_mm)
interface icache_ctrl_nway_if #(
   parameter int SETS           = 16,
   parameter int WAYS           = 2,
   parameter int WORDS_PER_LINE = 8
);
   localparam int SW = icache_pkg::idx_w(SETS);
   localparam int CW = icache_pkg::idx_w(WORDS_PER_LINE);
   logic            re_imem;
   logic [SW-1:0]   set_idx;
   logic [WAYS-1:0] hit_way;
   logic [WAYS-1:0] valid_way;
   logic            mem_valid_mm;
   logic            mem_err_mm;
   logic            clr;
   logic [SW-1:0]   clr_idx;
   logic            mem_valid_l1;
   logic            re_mm;
   logic            reset_mm;
   logic            we_cl;
   logic [CW-1:0]   cl_word;
   logic            we_imem;
   logic [WAYS-1:0] fill_way;
   logic [SW-1:0]   fill_set;
   logic            miss_err;
   modport master (
      input  re_imem, set_idx, hit_way, valid_way, mem_valid_mm, mem_err_mm,
      output clr, clr_idx, mem_valid_l1, re_mm, reset_mm, we_cl, cl_word, we_imem,
             fill_way, fill_set, miss_err
   );
   modport slave (
      output re_imem, set_idx, hit_way, valid_way, mem_valid_mm, mem_err_mm,
      input  clr, clr_idx, mem_valid_l1, re_mm, reset_mm, we_cl, cl_word, we_imem,
             fill_way, fill_set, miss_err
   );
endinterface

// File: rtl/icache_victim_sel.sv
// icache_victim_sel: per-set round-robin victim choice for line fills.
//   clk, reset (async, active-low), set_idx/valid_way : set under lookup and its valid bits
//   adv, adv_set, adv_way : fill-done strobe, filled set and one-hot filled way
//   victim : one-hot way to fill; lowest invalid way, else the set's round-robin pointer
module icache_victim_sel import icache_pkg::*; #(
   parameter int SETS = 16,
   parameter int WAYS = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [idx_w(SETS)-1:0]   set_idx,
   input  logic [WAYS-1:0]          valid_way,
   input  logic                     adv,
   input  logic [idx_w(SETS)-1:0]   adv_set,
   input  logic [WAYS-1:0]          adv_way,
   output logic [WAYS-1:0]          victim
);
   localparam int IW = idx_w(WAYS);
   logic [WAYS-1:0] free, rr_oh;
   assign free = ~valid_way;
   // free & -free keeps only the lowest free way
   assign victim = |free ? free & (~free + 1'b1) : rr_oh;
   generate
      if (WAYS > 1) begin : g_rr
         logic [IW-1:0] rr [SETS];
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) for (int s = 0; s < SETS; s++) rr[s] <= '0;
            else if (adv) rr[adv_set] <= IW'(oh2idx(32'(adv_way)) + 1);
         end
         assign rr_oh = WAYS'(1) << rr[set_idx];
      end else begin : g_one
         assign rr_oh = 1'b1;
      end
   endgenerate
endmodule

// File: rtl/icache_ctrl_nway.sv
// icache_ctrl_nway: n-way instruction-cache controller (valid sweep, line fetch, line fill).
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset
//   bus (master)   : CPU request / tag status in, memory port and array controls out
//   hit_cnt, miss_cnt : saturating hit/miss counters, present only with ICACHE_PERF_CNT_EN
module icache_ctrl_nway import icache_pkg::*; #(
   parameter int SETS           = 16,
   parameter int WAYS           = 2,
   parameter int WORDS_PER_LINE = 8
) (
   input  logic                clk,
   input  logic                reset,
`ifdef ICACHE_PERF_CNT_EN
   output logic [31:0]         hit_cnt,
   output logic [31:0]         miss_cnt,
`endif
   icache_ctrl_nway_if.master  bus
);
   localparam int SW = idx_w(SETS);
   localparam int CW = idx_w(WORDS_PER_LINE);
   state_t          state;
   logic [SW-1:0]   clr_idx_q, fill_set_q;
   logic [CW-1:0]   cnt;
   logic [WAYS-1:0] fill_way_q, victim;
   logic            hit, miss, last_word, mem_ok;
   assign hit       = state == CHECK && bus.re_imem && |bus.hit_way;
   assign miss      = state == CHECK && bus.re_imem && !(|bus.hit_way);
   assign mem_ok    = state == FETCH && bus.mem_valid_mm && !bus.mem_err_mm;
   assign last_word = cnt == CW'(WORDS_PER_LINE - 1);
   icache_victim_sel #(.SETS(SETS), .WAYS(WAYS)) u_victim (
      .clk,
      .reset,
      .set_idx   (bus.set_idx),
      .valid_way (bus.valid_way),
      .adv       (state == FILL && last_word),
      .adv_set   (fill_set_q),
      .adv_way   (fill_way_q),
      .victim
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= INIT;
         clr_idx_q  <= '0;
         cnt        <= '0;
         fill_way_q <= '0;
         fill_set_q <= '0;
      end else begin
         case (state)
            INIT: begin
               clr_idx_q <= (clr_idx_q == SW'(SETS - 1)) ? '0 : clr_idx_q + 1'b1;
               if (clr_idx_q == SW'(SETS - 1)) state <= CHECK;
            end
            CHECK: if (miss) begin
               fill_set_q <= bus.set_idx;
               fill_way_q <= victim;
               cnt        <= '0;
               state      <= FETCH;
            end
            FETCH: if (bus.mem_err_mm) begin
               cnt   <= '0;
               state <= CHECK;
            end else if (bus.mem_valid_mm) begin
               cnt <= last_word ? '0 : cnt + 1'b1;
               if (last_word) state <= FILL;
            end
            FILL: begin
               cnt <= last_word ? '0 : cnt + 1'b1;
               if (last_word) state <= CHECK;
            end
            default: state <= INIT;
         endcase
      end
   end
   // state sits at INIT during reset, so the sweep strobe is gated to keep outputs low
   assign bus.clr          = reset && state == INIT;
   assign bus.clr_idx      = clr_idx_q;
   assign bus.mem_valid_l1 = hit;
   assign bus.re_mm        = state == FETCH;
   assign bus.reset_mm     = miss || (mem_ok && last_word);
   assign bus.we_cl        = mem_ok;
   assign bus.cl_word      = cnt;
   assign bus.we_imem      = state == FILL;
   assign bus.fill_way     = fill_way_q;
   assign bus.fill_set     = fill_set_q;
   assign bus.miss_err     = state == FETCH && bus.mem_err_mm;
`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
         if (miss && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_ctrl_nway.sv
// tb_icache_ctrl_nway: directed self-checking bench for icache_ctrl_nway (16 sets, 2 ways, 8 words).
module tb_icache_ctrl_nway;
   typedef struct {
      int         lat;
      int         ncl;
      int         nim;
      int         nerr;
      int         nrm;
      int         cl_bad;
      int         first_im;
      logic [1:0] fw;
   } res_t;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          passed = 0;
   int          total = 0;
   logic [19:0] outs;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif
   icache_ctrl_nway_if #(.SETS(16), .WAYS(2), .WORDS_PER_LINE(8)) bus ();
   icache_ctrl_nway #(.SETS(16), .WAYS(2), .WORDS_PER_LINE(8)) dut (
      .clk      (clk),
      .reset    (reset),
`ifdef ICACHE_PERF_CNT_EN
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt),
`endif
      .bus      (bus)
   );
   always #5 clk = ~clk;
   assign outs = {bus.clr, bus.clr_idx, bus.mem_valid_l1, bus.re_mm, bus.reset_mm, bus.we_cl,
                  bus.cl_word, bus.we_imem, bus.fill_way, bus.fill_set, bus.miss_err};

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   // Issues one miss and feeds memory (a word every `gap` cycles, error on word err_at),
   // re-issuing the request as a hit on the filled way once 8 array writes were seen.
   task automatic run_miss(input logic [3:0] s, input logic [1:0] vw, input int gap,
                           input int err_at, output res_t r);
      int words = 0;
      r.lat = -1; r.ncl = 0; r.nim = 0; r.nerr = 0; r.nrm = 0; r.cl_bad = 0;
      r.first_im = -1; r.fw = 2'b00;
      cyc;
      bus.set_idx = s; bus.valid_way = vw; bus.hit_way = 2'b00; bus.re_imem = 1'b1;
      bus.mem_valid_mm = 1'b0; bus.mem_err_mm = 1'b0;
      #1;
      r.nrm += int'(bus.reset_mm);
      for (int c = 1; c <= 200; c++) begin
         cyc;
         bus.mem_valid_mm = (c % gap == 0);
         bus.mem_err_mm   = bus.mem_valid_mm && words == err_at;
         bus.hit_way      = (r.nim == 8) ? r.fw : 2'b00;
         #1;
         if (c == 1) r.fw = bus.fill_way;
         if (bus.re_mm && bus.cl_word != 3'(words)) r.cl_bad++;
         if (bus.we_imem && bus.cl_word != 3'(r.nim)) r.cl_bad++;
         if (bus.re_mm && bus.mem_valid_mm && !bus.mem_err_mm) words++;
         if (bus.we_imem && r.first_im < 0) r.first_im = c;
         r.ncl  += int'(bus.we_cl);
         r.nim  += int'(bus.we_imem);
         r.nerr += int'(bus.miss_err);
         r.nrm  += int'(bus.reset_mm);
         if (bus.miss_err || bus.mem_valid_l1) begin
            r.lat = c;
            break;
         end
      end
      cyc;
      bus.re_imem = 1'b0; bus.hit_way = 2'b00; bus.mem_valid_mm = 1'b0; bus.mem_err_mm = 1'b0;
   endtask

   task automatic test_reset;
      bus.re_imem = 1'b1; bus.hit_way = 2'b01; bus.valid_way = 2'b00; bus.set_idx = 4'd0;
      bus.mem_valid_mm = 1'b0; bus.mem_err_mm = 1'b0;
      repeat (3) cyc;
      #1;
      total++; if (outs !== 20'h0) $display("FAIL rst_outs got %h exp %h", outs, 20'h0); else passed++;
      cyc;
      reset = 1'b1;
      #1;
      total++;
      if ({bus.clr, bus.clr_idx, bus.mem_valid_l1} !== 6'b1_0000_0)
         $display("FAIL init_0 got %b exp %b", {bus.clr, bus.clr_idx, bus.mem_valid_l1}, 6'b1_0000_0);
      else passed++;
      for (int k = 1; k < 16; k++) begin
         cyc;
         #1;
         total++;
         if ({bus.clr, bus.clr_idx, bus.mem_valid_l1} !== {1'b1, 4'(k), 1'b0})
            $display("FAIL init_%0d got %b exp %b", k, {bus.clr, bus.clr_idx, bus.mem_valid_l1}, {1'b1, 4'(k), 1'b0});
         else passed++;
      end
      cyc;
      #1;
      total++;
      if ({bus.clr, bus.mem_valid_l1} !== 2'b01)
         $display("FAIL init_done got %b exp %b", {bus.clr, bus.mem_valid_l1}, 2'b01);
      else passed++;
      bus.re_imem = 1'b0; bus.hit_way = 2'b00;
   endtask

   task automatic test_cold_miss;
      res_t r;
      run_miss(4'd3, 2'b00, 1, -1, r);
      total++; if (r.fw !== 2'b01) $display("FAIL cold_fw got %b exp %b", r.fw, 2'b01); else passed++;
      total++; if (r.lat !== 17) $display("FAIL cold_lat got %0d exp %0d", r.lat, 17); else passed++;
      total++; if (r.ncl !== 8) $display("FAIL cold_we_cl got %0d exp %0d", r.ncl, 8); else passed++;
      total++; if (r.nim !== 8) $display("FAIL cold_we_imem got %0d exp %0d", r.nim, 8); else passed++;
      total++; if (r.nrm !== 2) $display("FAIL cold_reset_mm got %0d exp %0d", r.nrm, 2); else passed++;
      total++; if (r.cl_bad !== 0) $display("FAIL cold_cl_word got %0d exp %0d", r.cl_bad, 0); else passed++;
      total++; if (r.first_im !== 9) $display("FAIL cold_fill_start got %0d exp %0d", r.first_im, 9); else passed++;
      total++; if (bus.fill_set !== 4'd3) $display("FAIL cold_fill_set got %0d exp %0d", bus.fill_set, 3); else passed++;
   endtask

   task automatic test_rr;
      res_t r;
      logic [1:0] exp_fw [3];
      exp_fw[0] = 2'b01; exp_fw[1] = 2'b10; exp_fw[2] = 2'b01;
      for (int i = 0; i < 3; i++) begin
         run_miss(4'd5, 2'b11, 1, -1, r);
         total++; if (r.fw !== exp_fw[i]) $display("FAIL rr_fw_%0d got %b exp %b", i, r.fw, exp_fw[i]); else passed++;
         total++; if (r.lat !== 17) $display("FAIL rr_lat_%0d got %0d exp %0d", i, r.lat, 17); else passed++;
      end
   endtask

   task automatic test_err;
      res_t r;
      run_miss(4'd5, 2'b11, 1, 3, r);
      total++; if (r.fw !== 2'b10) $display("FAIL err_fw got %b exp %b", r.fw, 2'b10); else passed++;
      total++; if (r.nerr !== 1) $display("FAIL err_pulses got %0d exp %0d", r.nerr, 1); else passed++;
      total++; if (r.ncl !== 3) $display("FAIL err_we_cl got %0d exp %0d", r.ncl, 3); else passed++;
      total++; if (r.nim !== 0) $display("FAIL err_we_imem got %0d exp %0d", r.nim, 0); else passed++;
      total++; if (r.lat !== 4) $display("FAIL err_cycle got %0d exp %0d", r.lat, 4); else passed++;
      cyc;
      bus.set_idx = 4'd5; bus.re_imem = 1'b1; bus.hit_way = 2'b10;
      #1;
      total++;
      if ({bus.re_mm, bus.mem_valid_l1} !== 2'b01)
         $display("FAIL err_back_check got %b exp %b", {bus.re_mm, bus.mem_valid_l1}, 2'b01);
      else passed++;
      bus.re_imem = 1'b0; bus.hit_way = 2'b00;
      run_miss(4'd5, 2'b11, 1, -1, r);
      total++; if (r.fw !== 2'b10) $display("FAIL err_rr_kept got %b exp %b", r.fw, 2'b10); else passed++;
      total++; if (r.lat !== 17) $display("FAIL err_refill_lat got %0d exp %0d", r.lat, 17); else passed++;
   endtask

   task automatic test_gapped;
      res_t r;
      run_miss(4'd7, 2'b01, 3, -1, r);
      total++; if (r.fw !== 2'b10) $display("FAIL gap_fw got %b exp %b", r.fw, 2'b10); else passed++;
      total++; if (r.ncl !== 8) $display("FAIL gap_we_cl got %0d exp %0d", r.ncl, 8); else passed++;
      total++; if (r.cl_bad !== 0) $display("FAIL gap_cl_word got %0d exp %0d", r.cl_bad, 0); else passed++;
      total++; if (r.first_im !== 25) $display("FAIL gap_fill_start got %0d exp %0d", r.first_im, 25); else passed++;
      total++; if (r.lat !== 33) $display("FAIL gap_lat got %0d exp %0d", r.lat, 33); else passed++;
   endtask

   task automatic test_reset_mid_fill;
      int n = 0;
      cyc;
      bus.set_idx = 4'd9; bus.valid_way = 2'b00; bus.hit_way = 2'b00; bus.re_imem = 1'b1;
      bus.mem_valid_mm = 1'b0; bus.mem_err_mm = 1'b0;
      repeat (8) begin
         cyc;
         bus.mem_valid_mm = 1'b1;
      end
      cyc;
      bus.mem_valid_mm = 1'b0;
      cyc;
      cyc;
      cyc;
      #1;
      total++;
      if ({bus.we_imem, bus.cl_word} !== 4'b1011)
         $display("FAIL mid_fill_word got %b exp %b", {bus.we_imem, bus.cl_word}, 4'b1011);
      else passed++;
      reset = 1'b0;
      #1;
      total++; if (outs !== 20'h0) $display("FAIL mid_rst_outs got %h exp %h", outs, 20'h0); else passed++;
`ifdef ICACHE_PERF_CNT_EN
      total++; if (hit_cnt !== 32'd0) $display("FAIL mid_rst_hit_cnt got %0d exp %0d", hit_cnt, 0); else passed++;
      total++; if (miss_cnt !== 32'd0) $display("FAIL mid_rst_miss_cnt got %0d exp %0d", miss_cnt, 0); else passed++;
`endif
      cyc;
      #1;
      total++; if (outs !== 20'h0) $display("FAIL mid_rst_hold got %h exp %h", outs, 20'h0); else passed++;
      cyc;
      reset = 1'b1; bus.re_imem = 1'b0;
      #1;
      total++; if (bus.clr_idx !== 4'd0) $display("FAIL resweep_start got %0d exp %0d", bus.clr_idx, 0); else passed++;
      for (int i = 0; i < 40 && bus.clr === 1'b1; i++) begin
         n++;
         cyc;
         #1;
      end
      total++; if (n !== 16) $display("FAIL resweep_len got %0d exp %0d", n, 16); else passed++;
      cyc;
      bus.re_imem = 1'b1; bus.hit_way = 2'b01;
      #1;
      total++; if (bus.mem_valid_l1 !== 1'b1) $display("FAIL post_rst_hit got %b exp %b", bus.mem_valid_l1, 1'b1); else passed++;
      cyc;
      bus.re_imem = 1'b0; bus.hit_way = 2'b00;
      #1;
`ifdef ICACHE_PERF_CNT_EN
      total++; if (hit_cnt !== 32'd1) $display("FAIL post_rst_hit_cnt got %0d exp %0d", hit_cnt, 1); else passed++;
`endif
      total++; if (bus.mem_valid_l1 !== 1'b0) $display("FAIL idle_no_hit got %b exp %b", bus.mem_valid_l1, 1'b0); else passed++;
   endtask

   initial begin
      test_reset;
      test_cold_miss;
      test_rr;
      test_err;
      test_gapped;
      test_reset_mid_fill;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/icache_ctrl_nway.md
Name: icache_ctrl_nway

Overview:
- Second-generation instruction-cache controller: parametrised set count, associativity and line length.
- Owns the valid-clear sweep, the fill word counter and per-set round-robin victim selection; the previous generation relied on an external full flag and supported one way only.
- Sits between the L1 tag/data arrays (tag compare stays external; per-way hit/valid vectors come in) and the main-memory read port.
- Handles line fetch into a line buffer, line write-back into the chosen way, and memory-error abort.

Parameters:
- SETS, 16, number of sets; power of 2, >=2.
- WAYS, 2, associativity; power of 2, >=1.
- WORDS_PER_LINE, 8, words per cache line; power of 2, >=2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- re_imem  in  1  CPU instruction read request.
- set_idx  in  $clog2(SETS)  set index of the current request.
- hit_way  in  WAYS  one-hot tag match for set_idx (valid already qualified).
- valid_way  in  WAYS  valid bits of set_idx.
- mem_valid_mm  in  1  main memory returns one word this cycle.
- mem_err_mm  in  1  main memory error; sampled only in FETCH.
- clr  out  1  clear valid bits of set clr_idx.
- clr_idx  out  $clog2(SETS)  set being cleared.
- mem_valid_l1  out  1  hit; data is valid for the CPU this cycle.
- re_mm  out  1  main memory read enable.
- reset_mm  out  1  one-cycle pulse that restarts the memory burst address.
- we_cl  out  1  write the returned word into the line buffer.
- cl_word  out  $clog2(WORDS_PER_LINE)  line buffer / array word index.
- we_imem  out  1  write line buffer word cl_word into the array.
- fill_way  out  WAYS  one-hot way being filled.
- fill_set  out  $clog2(SETS)  set latched at miss.
- miss_err  out  1  one-cycle pulse: fill aborted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state <= INIT; clr_idx, word counter and all RR pointers <= 0; fill_way and fill_set <= 0.
  - All outputs 0 while reset is asserted, including mid-fill (the fill is dropped).
- INIT:
  - clr=1 for exactly SETS cycles, clr_idx counting 0..SETS-1.
  - After index SETS-1, go to CHECK. re_imem is ignored during INIT.
- CHECK:
  - re_imem & |hit_way: mem_valid_l1=1 combinationally, stay in CHECK.
  - re_imem & ~|hit_way: latch set_idx into fill_set; latch victim into fill_way; reset_mm=1; word counter <= 0; go to FETCH.
  - Victim selection: the lowest-index way with valid_way=0; if all ways are valid, the way given by RR[set_idx].
- FETCH:
  - re_mm=1 and cl_word=counter every cycle.
  - When mem_valid_mm=1: we_cl=1 and counter += 1.
  - On the last word (counter==WORDS_PER_LINE-1 & mem_valid_mm): reset_mm=1, counter <= 0, go to FILL.
  - mem_err_mm=1 takes priority over mem_valid_mm in the same cycle: no we_cl, miss_err=1, counter <= 0, go to CHECK. RR is not advanced and no array write occurs.
- FILL:
  - we_imem=1 and cl_word=counter every cycle; counter increments each cycle.
  - After word WORDS_PER_LINE-1: counter <= 0, RR[fill_set] <= (fill_way index + 1) mod WAYS, go to CHECK.
  - The re-issued request then hits.
- Latency: a hit is 0 cycles. A miss with memory delivering a word every cycle costs 1 + WORDS_PER_LINE + WORDS_PER_LINE cycles before the hit cycle (8 words: 17 cycles).
- fill_way and fill_set hold their values from the miss until the next miss.
- WAYS=1: RR pointers are absent; victim is always way 0.
- Counters wrap strictly by their terminal compares and never exceed WORDS_PER_LINE-1.
- Illegal state encoding: next state is INIT.

Optional Feature:
- ICACHE_PERF_CNT_EN defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each mem_valid_l1 cycle; miss_cnt increments on each CHECK->FETCH transition.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- ICACHE_PERF_CNT_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package icache_pkg holds:
  - the state_t enum (INIT, CHECK, FETCH, FILL), 2-bit;
  - the derived-width localparam functions;
  - the one-hot-to-index function.
- One sub-module, icache_victim_sel: holds the RR pointer array, computes victim from valid_way and set_idx, and advances on a fill-done strobe.

Test Plan:
- Reset release with SETS=16: clr=1 for 16 cycles, clr_idx 0..15, then CHECK; re_imem held high during INIT gives no mem_valid_l1.
- Cold miss at set 3 with all valid_way=0: fill_way=2'b01, reset_mm pulse, 8 we_cl pulses on 8 mem_valid_mm, then 8 we_imem cycles with cl_word 0..7, then hit gives mem_valid_l1 17 cycles after the miss.
- Set 5 fully valid, RR=0: two successive misses give fill_way 2'b01 then 2'b10; a third miss gives 2'b01.
- mem_valid_mm gapped (1 every 3 cycles): we_cl count stays 8, cl_word advances only on valid cycles, and FILL is entered only after the 8th word.
- mem_err_mm on the 4th word: miss_err pulses once, we_cl does not fire that cycle, no we_imem, RR[set] unchanged, and state returns to CHECK.
- reset asserted during FILL word 3: all outputs drop to 0 immediately; on release a full 16-cycle INIT sweep runs; with ICACHE_PERF_CNT_EN, hit_cnt and miss_cnt read 0.
